sample0_mul_acc_pipe: RTL and testbench

SAMPLE0_MUL_ACC_PIPE -- requirements
Module: sample0_mul_acc_pipe

---
 rtl/sample0_mac_pkg.sv | 23 ++
 rtl/sample0_mul_acc_pipe_mult.sv | 66 ++++++
 rtl/sample0_mul_acc_pipe.sv | 113 +++++++++++
 tb/tb_sample0_mul_acc_pipe.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sample0_mac_pkg.sv
// Shared constants for the sample0 multiply-accumulate pipeline.
// Holds the default widths, the minimum multiplier depth and the helpers
// that give the signed saturation limits for a given result width.
package sample0_mac_pkg;

  localparam int DEF_DIN0_WIDTH = 14;
  localparam int DEF_DIN1_WIDTH = 14;
  localparam int DEF_ACC_WIDTH  = 32;
  localparam int DEF_DOUT_WIDTH = 16;
  localparam int DEF_NUM_STAGE  = 3;
  localparam int MIN_NUM_STAGE  = 2;

  // Largest value representable in a w-bit two's complement result.
  function automatic logic signed [63:0] sat_hi(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a w-bit two's complement result.
  function automatic logic signed [63:0] sat_lo(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/sample0_mul_acc_pipe_mult.sv
// Signed multiplier pipeline, NUM_STAGE registers deep.
// Stage 1 registers the operands, stage 2 the full-precision product and
// any further stages simply delay it. The valid/clr/last side-band bits
// travel in lock-step with the data so the accumulator sees them aligned.
module sample0_mul_acc_pipe_mult
  import sample0_mac_pkg::*;
#(
  parameter int A_WIDTH   = DEF_DIN0_WIDTH,
  parameter int B_WIDTH   = DEF_DIN1_WIDTH,
  parameter int NUM_STAGE = DEF_NUM_STAGE
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ce,
  input  logic                              in_valid,
  input  logic signed [A_WIDTH-1:0]         a,
  input  logic signed [B_WIDTH-1:0]         b,
  input  logic                              clr,
  input  logic                              last,
  output logic                              out_valid,
  output logic signed [A_WIDTH+B_WIDTH-1:0] prod,
  output logic                              out_clr,
  output logic                              out_last
);

  localparam int STAGES = (NUM_STAGE < MIN_NUM_STAGE) ? MIN_NUM_STAGE : NUM_STAGE;
  localparam int PW     = A_WIDTH + B_WIDTH;

  logic signed [A_WIDTH-1:0] a_r;
  logic signed [B_WIDTH-1:0] b_r;
  logic [STAGES-1:0]         v_pipe;
  logic [STAGES-1:0]         c_pipe;
  logic [STAGES-1:0]         l_pipe;
  logic signed [PW-1:0]      p_pipe [1:STAGES-1];

  // Advance operands, product and side-band bits by one stage per enabled edge.
  // clr/last are qualified by in_valid here so ignored beats carry nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r    <= '0;
      b_r    <= '0;
      v_pipe <= '0;
      c_pipe <= '0;
      l_pipe <= '0;
      for (int i = 1; i < STAGES; i++) begin
        p_pipe[i] <= '0;
      end
    end else if (ce) begin
      a_r       <= a;
      b_r       <= b;
      v_pipe    <= {v_pipe[STAGES-2:0], in_valid};
      c_pipe    <= {c_pipe[STAGES-2:0], in_valid & clr};
      l_pipe    <= {l_pipe[STAGES-2:0], in_valid & last};
      p_pipe[1] <= PW'(a_r) * PW'(b_r);
      for (int i = 2; i < STAGES; i++) begin
        p_pipe[i] <= p_pipe[i-1];
      end
    end
  end

  assign out_valid = v_pipe[STAGES-1];
  assign out_clr   = c_pipe[STAGES-1];
  assign out_last  = l_pipe[STAGES-1];
  assign prod      = p_pipe[STAGES-1];

endmodule

// File: rtl/sample0_mul_acc_pipe.sv
// Pipelined signed multiply-accumulate with clear/last framing.
// Products from the multiplier pipeline are summed into a wide accumulator;
// the beat flagged last produces a one-cycle result strobe.
// Optional feature: define SAMPLE0_MAC_SAT_EN to clamp the result to the
// DOUT_WIDTH signed range and flag ovf; otherwise the result wraps.
module sample0_mul_acc_pipe
  import sample0_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = DEF_DIN0_WIDTH,
  parameter int DIN1_WIDTH = DEF_DIN1_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
  parameter int NUM_STAGE  = DEF_NUM_STAGE
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         acc_clr,
  input  logic                         acc_last,
  output logic                         out_valid,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         ovf
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

  logic                        m_valid;
  logic                        m_clr;
  logic                        m_last;
  logic signed [PW-1:0]        m_prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [DOUT_WIDTH-1:0] res;
  logic                        res_ovf;

  sample0_mul_acc_pipe_mult #(
    .A_WIDTH   (DIN0_WIDTH),
    .B_WIDTH   (DIN1_WIDTH),
    .NUM_STAGE (NUM_STAGE)
  ) u_mult (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .a         (din0),
    .b         (din1),
    .clr       (acc_clr),
    .last      (acc_last),
    .out_valid (m_valid),
    .prod      (m_prod),
    .out_clr   (m_clr),
    .out_last  (m_last)
  );

  assign prod_ext = ACC_WIDTH'(m_prod);

  // A clr beat starts a fresh sum; any other beat adds onto the running total.
  always_comb begin
    acc_next = acc + prod_ext;
    if (m_clr) begin
      acc_next = prod_ext;
    end
  end

`ifdef SAMPLE0_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(sat_hi(DOUT_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(sat_lo(DOUT_WIDTH));

  // Clamp the finished sum into the result range and remember if we had to.
  always_comb begin
    res     = DOUT_WIDTH'(acc_next);
    res_ovf = 1'b0;
    if (acc_next > SAT_HI) begin
      res     = SAT_HI[DOUT_WIDTH-1:0];
      res_ovf = 1'b1;
    end else if (acc_next < SAT_LO) begin
      res     = SAT_LO[DOUT_WIDTH-1:0];
      res_ovf = 1'b1;
    end
  end
`else
  // Without saturation the result is just the low bits of the sum.
  always_comb begin
    res     = DOUT_WIDTH'(acc_next);
    res_ovf = 1'b0;
  end
`endif

  // Accumulate valid product beats and capture the result on the last one;
  // dout/ovf keep their value until the next strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
    end else if (ce) begin
      out_valid <= m_valid & m_last;
      if (m_valid) begin
        acc <= acc_next;
      end
      if (m_valid && m_last) begin
        dout <= res;
        ovf  <= res_ovf;
      end
    end
  end

endmodule

// File: tb/tb_sample0_mul_acc_pipe.sv
// Self-checking bench for sample0_mul_acc_pipe at default parameters.
// Expected sums are pushed to a scoreboard when the last beat is issued;
// a negedge monitor pops and compares whenever a result strobe appears.
// Builds with or without SAMPLE0_MAC_SAT_EN.
module tb_sample0_mul_acc_pipe;

  logic               clk = 1'b0;
  logic               reset;
  logic               ce;
  logic               in_valid;
  logic signed [13:0] din0;
  logic signed [13:0] din1;
  logic               acc_clr;
  logic               acc_last;
  logic               out_valid;
  logic signed [15:0] dout;
  logic               ovf;

`ifdef SAMPLE0_MAC_SAT_EN
  localparam int E_SAT4_D = 32767;
  localparam int E_SAT4_O = 1;
  localparam int E_MIN_D  = 32767;
  localparam int E_MIN_O  = 1;
  localparam int E_NEG_D  = -32768;
  localparam int E_NEG_O  = 1;
`else
  localparam int E_SAT4_D = -25536;
  localparam int E_SAT4_O = 0;
  localparam int E_MIN_D  = 0;
  localparam int E_MIN_O  = 0;
  localparam int E_NEG_D  = 8192;
  localparam int E_NEG_O  = 0;
`endif

  typedef struct {
    int    d;
    int    o;
    int    at_edge;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_vec    = 0;
  int   n_bad    = 0;
  int   en_edges = 0;
  int   last_chk = -1;

  always #5 clk = ~clk;

  sample0_mul_acc_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .din0      (din0),
    .din1      (din1),
    .acc_clr   (acc_clr),
    .acc_last  (acc_last),
    .out_valid (out_valid),
    .dout      (dout),
    .ovf       (ovf)
  );

  // Count clock-enabled edges; latency is measured in these.
  always @(posedge clk) begin
    if (ce) en_edges <= en_edges + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int required);
    n_vec++;
    if (actual != required) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  // Monitor: each new strobe (one per enabled edge) is matched to the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && en_edges != last_chk) begin
      last_chk = en_edges;
      if (sb.size() == 0) begin
        checkOutput("spurious_strobe", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput({e.name, "_dout"}, int'(dout), e.d);
        checkOutput({e.name, "_ovf"}, int'(ovf), e.o);
        checkOutput({e.name, "_latency"}, en_edges, e.at_edge);
      end
    end
  end

  // Drive one valid beat for one enabled edge; a last beat queues its result.
  task automatic applyStimulus(input int a, input int b, input bit clr, input bit last,
                               input int exp_d, input int exp_o, input string name);
    exp_t e;
    in_valid = 1'b1;
    din0     = 14'(a);
    din1     = 14'(b);
    acc_clr  = clr;
    acc_last = last;
    @(posedge clk);
    #1;
    if (last) begin
      e.d       = exp_d;
      e.o       = exp_o;
      e.at_edge = en_edges + 3;
      e.name    = name;
      sb.push_back(e);
    end
    in_valid = 1'b0;
    acc_clr  = 1'b0;
    acc_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic stall(input int n);
    ce = 1'b0;
    idle(n);
    ce = 1'b1;
  endtask

  initial begin
    reset    = 1'b1;
    ce       = 1'b0;
    in_valid = 1'b0;
    din0     = '0;
    din1     = '0;
    acc_clr  = 1'b0;
    acc_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_dout", int'(dout), 0);
    checkOutput("reset_ovf", int'(ovf), 0);
    reset = 1'b0;
    ce    = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(3, -5, 1, 1, -15, 0, "single");
    idle(6);

    applyStimulus(100, 100, 1, 0, 0, 0, "");
    applyStimulus(100, 100, 0, 0, 0, 0, "");
    applyStimulus(100, 100, 0, 0, 0, 0, "");
    applyStimulus(100, 100, 0, 1, E_SAT4_D, E_SAT4_O, "sum4");
    idle(6);

    applyStimulus(-8192, -8192, 1, 1, E_MIN_D, E_MIN_O, "minmin");
    idle(6);

    applyStimulus(-8192, 8191, 1, 1, E_NEG_D, E_NEG_O, "neg_big");
    idle(6);

    applyStimulus(7, 2, 1, 0, 0, 0, "");
    stall(5);
    applyStimulus(1, 1, 0, 1, 15, 0, "stall_between");
    idle(6);

    applyStimulus(4, 4, 1, 1, 16, 0, "stall_inflight");
    stall(3);
    idle(6);

    applyStimulus(10, 10, 1, 0, 0, 0, "");
    in_valid = 1'b0;
    din0     = 14'sd99;
    din1     = 14'sd99;
    acc_clr  = 1'b1;
    acc_last = 1'b1;
    idle(1);
    acc_clr  = 1'b0;
    acc_last = 1'b0;
    applyStimulus(1, -1, 0, 1, 99, 0, "ignored_beat");
    idle(6);

    applyStimulus(1, 1, 1, 0, 0, 0, "");
    applyStimulus(2, 2, 0, 1, 5, 0, "b2b_first");
    applyStimulus(3, 3, 1, 1, 9, 0, "b2b_second");
    idle(6);

    applyStimulus(1, 1, 1, 0, 0, 0, "");
    applyStimulus(2, 2, 0, 0, 0, 0, "");
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midsum_reset_out_valid", int'(out_valid), 0);
    checkOutput("midsum_reset_dout", int'(dout), 0);
    checkOutput("midsum_reset_ovf", int'(ovf), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(2, 2, 1, 1, 4, 0, "post_reset");
    idle(6);

    applyStimulus(5, 1, 0, 1, 9, 0, "no_clr");
    idle(2);

    for (int i = 0; i < 100 && sb.size() > 0; i++) begin
      @(posedge clk);
    end
    idle(2);
    checkOutput("drain_pending", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
